// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Inter-stage pipeline register with stall/flush, valid bit,
//               Tnew decrement, GRF write-enable masking and stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int DATA_W           = 128,
  parameter int TNEW_W           = 2,
  parameter int TNEW_DEC         = 1,
  parameter int KEEP_PC_ON_FLUSH = 1,
  parameter int CNT_W            = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [31:0]       pc_in,
  input  logic [4:0]        wa_in,
  input  logic              grfwe_in,
  input  logic [TNEW_W-1:0] tnew_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic [31:0]       pc_out,
  output logic [4:0]        wa_out,
  output logic              grfwe_out,
  output logic [TNEW_W-1:0] tnew_out,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [TNEW_W:0]  c_tnew_dec = (TNEW_W+1)'(TNEW_DEC);
  localparam logic [CNT_W-1:0] c_cnt_max  = '1;
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [31:0]       r_pc;
  logic [4:0]        r_wa;
  logic              r_grfwe;
  logic [TNEW_W-1:0] r_tnew;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic [TNEW_W:0]   w_tnew_ext;
  logic [TNEW_W:0]   w_tnew_diff;
  logic [TNEW_W-1:0] w_tnew_next;
  logic              w_grfwe_next;
  logic [31:0]       w_pc_bubble;

  // Subtract one bit wider so an underflow is detected and clamped to zero.
  assign w_tnew_ext   = {1'b0, tnew_in};
  assign w_tnew_diff  = w_tnew_ext - c_tnew_dec;
  assign w_tnew_next  = (w_tnew_ext < c_tnew_dec) ? '0 : w_tnew_diff[TNEW_W-1:0];

  // A bubble or a write to $0 must never raise a downstream write.
  assign w_grfwe_next = grfwe_in & valid_in & (wa_in != 5'd0);
  assign w_pc_bubble  = (KEEP_PC_ON_FLUSH != 0) ? pc_in : 32'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_pc        <= '0;
      r_wa        <= '0;
      r_grfwe     <= 1'b0;
      r_tnew      <= '0;
      r_stall_cnt <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_pc    <= w_pc_bubble;
      r_wa    <= '0;
      r_grfwe <= 1'b0;
      r_tnew  <= '0;
    end else if (stall) begin
      if (r_valid && (r_stall_cnt != c_cnt_max)) begin
        r_stall_cnt <= r_stall_cnt + c_cnt_one;
      end
    end else begin
      r_valid <= valid_in;
      r_data  <= data_in;
      r_pc    <= pc_in;
      r_wa    <= wa_in;
      r_grfwe <= w_grfwe_next;
      r_tnew  <= w_tnew_next;
    end
  end

  assign valid_out = r_valid;
  assign data_out  = r_data;
  assign pc_out    = r_pc;
  assign wa_out    = r_wa;
  assign grfwe_out = r_grfwe;
  assign tnew_out  = r_tnew;
  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Directed bench for pipe_stage_reg over three parameter sets,
//               checked against a behavioural model and literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

  localparam int c_dw = 32;

  typedef struct {
    int          valid;
    logic [31:0] data;
    logic [31:0] pc;
    int          wa;
    int          we;
    int          tnew;
    int          cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset, stall, flush, valid_in, grfwe_in;
  logic [c_dw-1:0] data_in;
  logic [31:0] pc_in;
  logic [4:0]  wa_in;
  logic [1:0]  tnew_in;

  // 0: defaults, 1: KEEP_PC_ON_FLUSH=0 TNEW_DEC=0, 2: CNT_W=4
  logic            v_o [3];
  logic [c_dw-1:0] d_o [3];
  logic [31:0]     p_o [3];
  logic [4:0]      w_o [3];
  logic            e_o [3];
  logic [1:0]      t_o [3];
  logic [15:0]     c_a, c_b;
  logic [3:0]      c_c;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;
  exp_t m [3];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(c_dw), .TNEW_W(2), .TNEW_DEC(1), .KEEP_PC_ON_FLUSH(1), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
    .data_in(data_in), .pc_in(pc_in), .wa_in(wa_in), .grfwe_in(grfwe_in), .tnew_in(tnew_in),
    .valid_out(v_o[0]), .data_out(d_o[0]), .pc_out(p_o[0]), .wa_out(w_o[0]),
    .grfwe_out(e_o[0]), .tnew_out(t_o[0]), .stall_cnt(c_a));

  pipe_stage_reg #(.DATA_W(c_dw), .TNEW_W(2), .TNEW_DEC(0), .KEEP_PC_ON_FLUSH(0), .CNT_W(16)) u_b (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
    .data_in(data_in), .pc_in(pc_in), .wa_in(wa_in), .grfwe_in(grfwe_in), .tnew_in(tnew_in),
    .valid_out(v_o[1]), .data_out(d_o[1]), .pc_out(p_o[1]), .wa_out(w_o[1]),
    .grfwe_out(e_o[1]), .tnew_out(t_o[1]), .stall_cnt(c_b));

  pipe_stage_reg #(.DATA_W(c_dw), .TNEW_W(2), .TNEW_DEC(1), .KEEP_PC_ON_FLUSH(1), .CNT_W(4)) u_c (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
    .data_in(data_in), .pc_in(pc_in), .wa_in(wa_in), .grfwe_in(grfwe_in), .tnew_in(tnew_in),
    .valid_out(v_o[2]), .data_out(d_o[2]), .pc_out(p_o[2]), .wa_out(w_o[2]),
    .grfwe_out(e_o[2]), .tnew_out(t_o[2]), .stall_cnt(c_c));

  function automatic exp_t model_next(exp_t cur, bit keep_pc, int dec, int cmax);
    exp_t n = cur;
    if (reset) begin
      n = '{0, 32'd0, 32'd0, 0, 0, 0, 0};
    end else if (flush) begin
      n.valid = 0; n.data = 0; n.wa = 0; n.we = 0; n.tnew = 0;
      n.pc = keep_pc ? pc_in : 32'd0;
    end else if (stall) begin
      if (cur.valid == 1 && cur.cnt < cmax) n.cnt = cur.cnt + 1;
    end else begin
      n.valid = int'(valid_in);
      n.data  = data_in;
      n.pc    = pc_in;
      n.wa    = int'(wa_in);
      n.we    = (valid_in && grfwe_in && wa_in != 0) ? 1 : 0;
      n.tnew  = (int'(tnew_in) - dec < 0) ? 0 : int'(tnew_in) - dec;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m[0] <= model_next(m[0], 1'b1, 1, 65535);
    m[1] <= model_next(m[1], 1'b0, 0, 65535);
    m[2] <= model_next(m[2], 1'b1, 1, 15);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [31:0] cnt_of(int i);
    case (i)
      0:       return {16'd0, c_a};
      1:       return {16'd0, c_b};
      default: return {28'd0, c_c};
    endcase
  endfunction

  // Model comparison on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("m%0d.valid", i), {31'd0, v_o[i]}, m[i].valid);
        chk($sformatf("m%0d.data", i),  d_o[i], m[i].data);
        chk($sformatf("m%0d.pc", i),    p_o[i], m[i].pc);
        chk($sformatf("m%0d.wa", i),    {27'd0, w_o[i]}, m[i].wa);
        chk($sformatf("m%0d.we", i),    {31'd0, e_o[i]}, m[i].we);
        chk($sformatf("m%0d.tnew", i),  {30'd0, t_o[i]}, m[i].tnew);
        chk($sformatf("m%0d.cnt", i),   cnt_of(i), m[i].cnt);
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v, logic [31:0] pc, logic [4:0] wa, bit we, logic [1:0] tn, logic [31:0] d);
    valid_in = v; pc_in = pc; wa_in = wa; grfwe_in = we; tnew_in = tn; data_in = d;
  endtask

  initial begin
    reset = 1; stall = 0; flush = 0;
    drive(1, 32'h1234, 5'd9, 1, 2'd3, 32'hdeadbeef);
    step(2);
    cmp_en = 1;
    // 1. reset with non-zero inputs, then first load
    chk("rst.valid", {31'd0, v_o[0]}, 0);
    chk("rst.pc", p_o[0], 0);
    chk("rst.data", d_o[0], 0);
    chk("rst.we", {31'd0, e_o[0]}, 0);
    chk("rst.cnt", {16'd0, c_a}, 0);
    reset = 0;
    drive(1, 32'h3000, 5'd5, 1, 2'd2, 32'h11);
    step();
    chk("ld.valid", {31'd0, v_o[0]}, 1);
    chk("ld.pc", p_o[0], 32'h3000);
    chk("ld.wa", {27'd0, w_o[0]}, 5);
    chk("ld.we", {31'd0, e_o[0]}, 1);
    chk("ld.tnew", {30'd0, t_o[0]}, 1);
    chk("ld.tnew_dec0", {30'd0, t_o[1]}, 2);
    // 2. stall hold and count
    drive(1, 32'h3004, 5'd6, 1, 2'd2, 32'h22);
    step();
    stall = 1;
    drive(1, 32'h3008, 5'd8, 1, 2'd3, 32'h33);
    step(3);
    chk("stall.pc", p_o[0], 32'h3004);
    chk("stall.tnew", {30'd0, t_o[0]}, 1);
    chk("stall.cnt", {16'd0, c_a}, 3);
    stall = 0;
    step();
    chk("unstall.pc", p_o[0], 32'h3008);
    // 3. flush wins over stall
    stall = 1; flush = 1;
    drive(1, 32'h300c, 5'd4, 1, 2'd3, 32'h44);
    step();
    chk("fl.valid", {31'd0, v_o[0]}, 0);
    chk("fl.we", {31'd0, e_o[0]}, 0);
    chk("fl.tnew", {30'd0, t_o[0]}, 0);
    chk("fl.pc_keep", p_o[0], 32'h300c);
    chk("fl.pc_zero", p_o[1], 0);
    chk("fl.cnt", {16'd0, c_a}, 3);
    flush = 0;
    step();
    chk("stall_bubble.cnt", {16'd0, c_a}, 3);
    stall = 0;
    // 4. tnew saturation
    drive(1, 32'h3010, 5'd5, 1, 2'd0, 32'h55);
    step();
    chk("tn0.dec1", {30'd0, t_o[0]}, 0);
    chk("tn0.dec0", {30'd0, t_o[1]}, 0);
    drive(1, 32'h3014, 5'd5, 1, 2'd2, 32'h66);
    step();
    chk("tn2.dec0", {30'd0, t_o[1]}, 2);
    chk("tn2.dec1", {30'd0, t_o[0]}, 1);
    drive(1, 32'h3018, 5'd5, 1, 2'd3, 32'h77);
    step();
    chk("tn3.dec1", {30'd0, t_o[0]}, 2);
    // 5. write-enable masking
    drive(1, 32'h301c, 5'd0, 1, 2'd1, 32'h88);
    step();
    chk("wa0.we", {31'd0, e_o[0]}, 0);
    drive(0, 32'h3020, 5'd7, 1, 2'd1, 32'h99);
    step();
    chk("inv.we", {31'd0, e_o[0]}, 0);
    chk("inv.wa", {27'd0, w_o[0]}, 7);
    chk("inv.valid", {31'd0, v_o[0]}, 0);
    // 6. counter saturation, then reset mid-stall
    drive(1, 32'h3024, 5'd3, 1, 2'd1, 32'haa);
    step();
    stall = 1;
    step(20);
    chk("sat.c", {28'd0, c_c}, 15);
    chk("sat.a", {16'd0, c_a}, 23);
    step();
    chk("sat.hold", {28'd0, c_c}, 15);
    reset = 1;
    step();
    chk("rst_stall.c", {28'd0, c_c}, 0);
    chk("rst_stall.a", {16'd0, c_a}, 0);
    reset = 0; stall = 0;
    // back-to-back loads, checked by the model
    for (int i = 0; i < 8; i++) begin
      drive(i[0], 32'h4000 + 32'(i * 4), 5'(i * 3), i[1], 2'(i), $urandom);
      step();
    end
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
